// File: rtl/la_seq_gcd.sv
// Sequential GCD engine using subtractive Euclid: one swap or subtract per cycle,
// with a valid/ready handshake on both the operand and the result side.
module la_seq_gcd #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_gcd,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Swap first so the subtraction below can never underflow.
        if (a_q < b_q) begin
          a_d = b_q;
          b_d = a_q;
        end else if (b_q != '0) begin
          a_d = a_q - b_q;
        end else begin
          gcd_d   = a_q;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // in_ready is gated by resetb so it reads low for the whole reset window.
  assign in_ready  = resetb && (state_q == S_IDLE);
  assign busy      = (state_q == S_CALC);
  assign out_valid = valid_q;
  assign out_gcd   = gcd_q;

endmodule

// File: tb/tb_la_seq_gcd.sv
// Self-checking bench for la_seq_gcd: directed vectors plus randomized operand
// pairs compared against a division-based Euclid reference model.
module tb_la_seq_gcd;

  localparam int W      = 32;
  localparam int BUDGET = 40000;

  logic         clock = 1'b0;
  logic         resetb = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_gcd;
  logic         out_ready = 1'b0;
  logic         busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  la_seq_gcd #(.WIDTH(W)) dut (
    .clock    (clock),
    .resetb   (resetb),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_gcd  (out_gcd),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Reference gcd by the remainder form of Euclid.
  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // CALC cycles: optional initial swap, then per division step q subtracts plus
  // one swap, then one final cycle that sees B==0.
  function automatic longint ref_steps(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, r;
    longint s;
    s = 0;
    x = a;
    y = b;
    if (x < y) begin
      x = b;
      y = a;
      s = s + 1;
    end
    while (y != 0) begin
      s = s + longint'(x / y) + 1;
      r = x % y;
      x = y;
      y = r;
    end
    return s + 1;
  endfunction

  task automatic wait_edge();
    @(posedge clock);
    #1;
  endtask

  // Offers one pair and waits for out_valid; leaves the result unconsumed.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] g, output int calc_cycles,
                          output int lat, output bit timed_out);
    int n;
    timed_out   = 1'b0;
    calc_cycles = 0;
    lat         = 0;
    g           = '0;
    n           = 0;
    while (!in_ready && n < 20) begin
      wait_edge();
      n++;
    end
    if (!in_ready) begin
      timed_out = 1'b1;
      return;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    wait_edge();
    lat      = 1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    while (!out_valid && lat < BUDGET) begin
      if (busy) calc_cycles++;
      wait_edge();
      lat++;
    end
    if (!out_valid) timed_out = 1'b1;
    g = out_gcd;
  endtask

  task automatic test_reset();
    resetb    = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    wait_edge();
    wait_edge();
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_gcd !== '0 || in_ready !== 1'b0)
      $display("FAIL reset_state got valid=%b busy=%b gcd=%0d ready=%b exp 0 0 0 0",
               out_valid, busy, out_gcd, in_ready);
    else pass_cnt++;
    #2 resetb = 1'b1;
    wait_edge();
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release got ready=%b busy=%b exp 1 0", in_ready, busy);
    else pass_cnt++;
    $display("reset: released, in_ready=%b", in_ready);
  endtask

  task automatic test_idle_ignore();
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = $urandom;
      in_b = $urandom;
      wait_edge();
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) ok = 1'b0;
    end
    total_cnt++;
    if (!ok) $display("FAIL idle_ignore got busy=%b ready=%b valid=%b exp 0 1 0",
                      busy, in_ready, out_valid);
    else pass_cnt++;
    $display("idle_ignore: 5 cycles with in_valid low");
  endtask

  task automatic test_spec_vector();
    logic [W-1:0] g;
    int cc, lat;
    bit to;
    out_ready = 1'b0;
    drive_op(32'd10312050, 32'd29460792, g, cc, lat, to);
    total_cnt++;
    if (to || g !== 32'd138 || out_valid !== 1'b1)
      $display("FAIL spec_vector got gcd=%0d valid=%b to=%0b exp 138 1", g, out_valid, to);
    else pass_cnt++;
    total_cnt++;
    if (longint'(cc) != ref_steps(32'd10312050, 32'd29460792) || longint'(lat) != ref_steps(32'd10312050, 32'd29460792) + 1)
      $display("FAIL spec_latency got calc=%0d lat=%0d exp calc=%0d", cc, lat,
               ref_steps(32'd10312050, 32'd29460792));
    else pass_cnt++;
    out_ready = 1'b1;
    wait_edge();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_gcd !== 32'd138)
      $display("FAIL spec_consume got valid=%b ready=%b gcd=%0d exp 0 1 138",
               out_valid, in_ready, out_gcd);
    else pass_cnt++;
    $display("spec_vector: gcd(10312050,29460792)=%0d calc=%0d lat=%0d", g, cc, lat);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [4] = '{32'd1993627629, 32'd2097015289, 32'd1924134885, 32'd992211318};
    logic [W-1:0] vb [4] = '{32'd1177417612, 32'd3812041926, 32'd3151131255, 32'd512609597};
    logic [W-1:0] ve [4] = '{32'd7, 32'd1, 32'd135, 32'd1};
    logic [W-1:0] g;
    int cc, lat;
    bit to;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_op(va[i], vb[i], g, cc, lat, to);
      total_cnt++;
      if (to || g !== ve[i] || longint'(cc) != ref_steps(va[i], vb[i]))
        $display("FAIL b2b_%0d got gcd=%0d calc=%0d to=%0b exp gcd=%0d calc=%0d",
                 i, g, cc, to, ve[i], ref_steps(va[i], vb[i]));
      else pass_cnt++;
      $display("back_to_back: gcd(%0d,%0d)=%0d calc=%0d", va[i], vb[i], g, cc);
    end
    wait_edge();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_drain got valid=%b ready=%b exp 0 1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_boundary();
    logic [W-1:0] va [4] = '{32'd0, 32'd0, 32'd25, 32'd12};
    logic [W-1:0] vb [4] = '{32'd0, 32'd25, 32'd0, 32'd12};
    logic [W-1:0] ve [4] = '{32'd0, 32'd25, 32'd25, 32'd12};
    logic [W-1:0] g;
    int cc, lat;
    bit to;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_op(va[i], vb[i], g, cc, lat, to);
      total_cnt++;
      if (to || g !== ve[i] || cc > 3 || longint'(cc) != ref_steps(va[i], vb[i]))
        $display("FAIL boundary_%0d got gcd=%0d calc=%0d exp gcd=%0d calc=%0d",
                 i, g, cc, ve[i], ref_steps(va[i], vb[i]));
      else pass_cnt++;
      $display("boundary: gcd(%0d,%0d)=%0d calc=%0d", va[i], vb[i], g, cc);
    end
    wait_edge();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, g, m;
    int cc, lat;
    bit to;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      m = W'($urandom_range(1, 65536));
      a = m * W'($urandom_range(0, 1500));
      b = m * W'($urandom_range(0, 1500));
      drive_op(a, b, g, cc, lat, to);
      total_cnt++;
      if (to || g !== ref_gcd(a, b) || longint'(lat) != ref_steps(a, b) + 1)
        $display("FAIL random_%0d a=%0d b=%0d got gcd=%0d lat=%0d exp gcd=%0d lat=%0d",
                 i, a, b, g, lat, ref_gcd(a, b), ref_steps(a, b) + 1);
      else pass_cnt++;
      $display("random: gcd(%0d,%0d)=%0d lat=%0d", a, b, g, lat);
    end
    wait_edge();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] g;
    int cc, lat;
    bit to, ok;
    out_ready = 1'b0;
    drive_op(32'd1071, 32'd462, g, cc, lat, to);
    total_cnt++;
    if (to || g !== 32'd21)
      $display("FAIL bp_result got gcd=%0d exp 21", g);
    else pass_cnt++;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a     = $urandom;
      in_b     = $urandom;
      wait_edge();
      if (out_valid !== 1'b1 || out_gcd !== 32'd21 || in_ready !== 1'b0 || busy !== 1'b0)
        ok = 1'b0;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (!ok) $display("FAIL bp_hold got valid=%b gcd=%0d ready=%b busy=%b exp 1 21 0 0",
                      out_valid, out_gcd, in_ready, busy);
    else pass_cnt++;
    out_ready = 1'b1;
    wait_edge();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got valid=%b ready=%b exp 0 1", out_valid, in_ready);
    else pass_cnt++;
    wait_edge();
    total_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_gcd !== 32'd21)
      $display("FAIL bp_no_queue got busy=%b valid=%b gcd=%0d exp 0 0 21",
               busy, out_valid, out_gcd);
    else pass_cnt++;
    $display("backpressure: held 10 cycles, gcd=%0d", out_gcd);
  endtask

  task automatic test_reset_mid_calc();
    logic [W-1:0] g;
    int cc, lat;
    bit to, ok;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'd10312050;
    in_b      = 32'd29460792;
    wait_edge();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) wait_edge();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL mid_calc_busy got busy=%b exp 1", busy);
    else pass_cnt++;
    resetb = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_gcd !== '0 || in_ready !== 1'b0)
      $display("FAIL reset_mid_calc got valid=%b busy=%b gcd=%0d ready=%b exp 0 0 0 0",
               out_valid, busy, out_gcd, in_ready);
    else pass_cnt++;
    wait_edge();
    wait_edge();
    resetb = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_edge();
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
    end
    total_cnt++;
    if (!ok) $display("FAIL reset_discard got valid=%b busy=%b ready=%b exp 0 0 1",
                      out_valid, busy, in_ready);
    else pass_cnt++;
    drive_op(32'd48, 32'd18, g, cc, lat, to);
    total_cnt++;
    if (to || g !== 32'd6)
      $display("FAIL post_reset got gcd=%0d exp 6", g);
    else pass_cnt++;
    wait_edge();
    $display("reset_mid_calc: post-reset gcd(48,18)=%0d", g);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_spec_vector();
    test_back_to_back();
    test_boundary();
    test_random();
    test_backpressure();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
